// File: rtl/ni_pkg.sv
// Shared flit layout, inject FSM state type and flit builders for the local
// network interface.
package ni_pkg;

    localparam int FLIT_W    = 17;
    localparam int PAYLOAD_W = 14;
    localparam int VALID     = 16;
    localparam int HDR       = 15;
    localparam int TAIL      = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } ni_state_t;

    // Header payload: [13:10] dest, [9:6] source, [5:3] body length, [2:0] zero.
    function automatic logic [FLIT_W-1:0] make_header(
        input logic [3:0] dest,
        input logic [3:0] src,
        input logic [2:0] len
    );
        return {1'b1, 1'b1, 1'b0, dest, src, len, 3'b000};
    endfunction

    function automatic logic [FLIT_W-1:0] make_body(
        input logic                 tail,
        input logic [PAYLOAD_W-1:0] data
    );
        return {1'b1, 1'b0, tail, data};
    endfunction

endpackage

// File: rtl/ni_eject_fifo.sv
// Eject-side flit FIFO: combinational head read, simultaneous push/pop allowed
// at any occupancy, sticky overflow flag when a flit is dropped.
module ni_eject_fifo
    import ni_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] din,
    input  logic              pop,
    output logic [FLIT_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              ovf_reg;
    logic              do_push;
    logic              do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_FULL);
    assign dout  = mem[rd_ptr_reg];
    assign ovf   = ovf_reg;

    // A pop frees the head slot in the same cycle, so a push into a full FIFO
    // is accepted whenever it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
            if (push && full && !do_pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/local_network_interface.sv
// Router local-port network interface: packetises core requests into header +
// body flits toward the router, and buffers ejected flits for the core.
module local_network_interface
    import ni_pkg::*;
#(
    parameter logic [3:0] ROUTER_ID = 4'd1,
    parameter int         EJ_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3:0]           req_dest_i,
    input  logic [2:0]           req_len_i,
    input  logic                 body_valid_i,
    input  logic [PAYLOAD_W-1:0] body_data_i,
    output logic                 body_ready_o,
    input  logic                 noc_full_i,
    output logic [FLIT_W-1:0]    noc_data_o,
    input  logic [FLIT_W-1:0]    noc_data_i,
    output logic                 ej_valid_o,
    output logic [FLIT_W-1:0]    ej_data_o,
    input  logic                 ej_ready_i,
    output logic                 ej_pop_o,
    output logic                 ej_ovf_o
);

    ni_state_t         state_reg, state_next;
    logic [3:0]        dest_reg, dest_next;
    logic [2:0]        len_reg, len_next;
    logic [2:0]        remaining_reg, remaining_next;
    logic [FLIT_W-1:0] noc_data_reg, noc_data_next;
    logic              ej_empty;
    logic              ej_full_unused;

    assign req_ready_o  = (state_reg == IDLE);
    assign body_ready_o = (state_reg == BODY) & body_valid_i & ~noc_full_i;
    assign noc_data_o   = noc_data_reg;

    // noc_data_next defaults to zero so every flit lives exactly one cycle;
    // the router counts each cycle with the valid bit set as a new flit.
    always_comb begin
        state_next     = state_reg;
        dest_next      = dest_reg;
        len_next       = len_reg;
        remaining_next = remaining_reg;
        noc_data_next  = '0;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    dest_next  = req_dest_i;
                    len_next   = (req_len_i == 3'd0) ? 3'd1 : req_len_i;
                    state_next = HEAD;
                end
            end
            HEAD: begin
                if (!noc_full_i) begin
                    noc_data_next  = make_header(dest_reg, ROUTER_ID, len_reg);
                    remaining_next = len_reg;
                    state_next     = BODY;
                end
            end
            BODY: begin
                if (body_ready_o) begin
                    noc_data_next  = make_body(remaining_reg == 3'd1, body_data_i);
                    remaining_next = remaining_reg - 3'd1;
                    if (remaining_reg == 3'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            dest_reg      <= '0;
            len_reg       <= '0;
            remaining_reg <= '0;
            noc_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            dest_reg      <= dest_next;
            len_reg       <= len_next;
            remaining_reg <= remaining_next;
            noc_data_reg  <= noc_data_next;
        end
    end

    assign ej_valid_o = ~ej_empty;
    assign ej_pop_o   = ej_valid_o & ej_ready_i;

    ni_eject_fifo #(
        .DEPTH(EJ_DEPTH)
    ) u_eject (
        .clk  (clk),
        .rst  (rst),
        .push (noc_data_i[VALID]),
        .din  (noc_data_i),
        .pop  (ej_pop_o),
        .dout (ej_data_o),
        .empty(ej_empty),
        .full (ej_full_unused),
        .ovf  (ej_ovf_o)
    );

endmodule

// File: tb/tb_local_network_interface.sv
// Self-checking bench for local_network_interface: directed and randomized
// injection/ejection checked against a queue-based packet and FIFO model.
module tb_local_network_interface;

    localparam logic [3:0] RID = 4'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_dest = '0;
    logic [2:0]  req_len = '0;
    logic        body_valid = 1'b0;
    logic [13:0] body_data = '0;
    logic        body_ready;
    logic        noc_full = 1'b0;
    logic [16:0] noc_data_out;
    logic [16:0] noc_data_in = '0;
    logic        ej_valid;
    logic [16:0] ej_data;
    logic        ej_ready = 1'b0;
    logic        ej_pop;
    logic        ej_ovf;

    local_network_interface #(
        .ROUTER_ID(RID),
        .EJ_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_dest_i  (req_dest),
        .req_len_i   (req_len),
        .body_valid_i(body_valid),
        .body_data_i (body_data),
        .body_ready_o(body_ready),
        .noc_full_i  (noc_full),
        .noc_data_o  (noc_data_out),
        .noc_data_i  (noc_data_in),
        .ej_valid_o  (ej_valid),
        .ej_data_o   (ej_data),
        .ej_ready_i  (ej_ready),
        .ej_pop_o    (ej_pop),
        .ej_ovf_o    (ej_ovf)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pop_seen = 0;
    logic [16:0] got[$];
    int          got_t[$];
    logic [13:0] fixed_words[$];
    logic [16:0] ej_model[$];
    logic        ovf_exp = 1'b0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and record any valid flit the NI drove.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (noc_data_out[16] === 1'b1) begin
            got.push_back(noc_data_out);
            got_t.push_back(cyc);
        end
    endtask

    task automatic run_packet(input logic [3:0] dest, input logic [2:0] len,
                              input int stall_pct, input int full_hold, input int abort_at);
        int          nb;
        int          idx;
        int          budget;
        int          held;
        logic        exp_br;
        logic [13:0] w;
        logic [13:0] words[$];
        logic [16:0] exp[$];

        nb = (len == 3'd0) ? 1 : int'(len);
        exp.push_back(17'h18000 | (17'(dest) << 10) | (17'(RID) << 6) | (17'(nb) << 3));
        for (int i = 0; i < nb; i++) begin
            if (fixed_words.size() > 0) w = fixed_words.pop_front();
            else w = 14'($urandom);
            words.push_back(w);
            exp.push_back(17'h10000 | ((i == nb - 1) ? 17'h04000 : 17'h0) | 17'(w));
        end
        got.delete();
        got_t.delete();

        budget = 0;
        while (!req_ready && budget < 50) begin
            cycle();
            budget++;
        end
        chk(32'(req_ready), 1, "req_ready_before_req");
        req_valid = 1'b1; req_dest = dest; req_len = len;
        body_valid = 1'b0; noc_full = 1'b0;
        cycle();

        idx = 0; held = 0; budget = 0;
        while (got.size() < nb + 1 && budget < 400) begin
            if (abort_at > 0 && got.size() == abort_at) return;
            // Requests while busy must be ignored, so keep offering junk ones.
            req_valid  = 1'($urandom_range(1));
            req_dest   = 4'($urandom);
            req_len    = 3'($urandom);
            body_valid = ($urandom_range(99) >= stall_pct);
            noc_full   = ($urandom_range(99) < stall_pct);
            if (got.size() >= 1 && held < full_hold) begin
                noc_full = 1'b1;
                held++;
            end
            body_data = (idx < nb) ? words[idx] : 14'($urandom);
            #1;
            exp_br = (got.size() >= 1) && body_valid && !noc_full;
            chk(32'(body_ready), 32'(exp_br), "body_ready");
            if (exp_br) idx++;
            cycle();
            budget++;
        end
        req_valid = 1'b0; body_valid = 1'b0; noc_full = 1'b0;

        chk(got.size(), nb + 1, "flit_count");
        for (int i = 0; i < nb + 1 && i < got.size(); i++) begin
            chk(32'(got[i]), 32'(exp[i]), $sformatf("flit[%0d]", i));
        end
        chk(32'(req_ready), 1, "req_ready_after_tail");
        if (full_hold > 0 && got_t.size() >= 2) begin
            chk(got_t[1] - got_t[0], full_hold + 1, "bubble_gap");
        end
        cycle();
        cycle();
        chk(got.size(), nb + 1, "no_extra_flit");
        chk(32'(noc_data_out), 0, "idle_noc_data");
        $display("packet dest=%h len=%0d flits=%0d", dest, len, got.size());
    endtask

    task automatic ej_step(input logic [16:0] flit, input logic rdy);
        logic exp_pop;
        logic was_full;
        noc_data_in = flit;
        ej_ready    = rdy;
        #1;
        chk(32'(ej_valid), 32'(ej_model.size() > 0), "ej_valid");
        if (ej_model.size() > 0) chk(32'(ej_data), 32'(ej_model[0]), "ej_data");
        exp_pop = rdy && (ej_model.size() > 0);
        chk(32'(ej_pop), 32'(exp_pop), "ej_pop");
        chk(32'(ej_ovf), 32'(ovf_exp), "ej_ovf");
        if (ej_pop === 1'b1) pop_seen++;
        was_full = (ej_model.size() == 4);
        if (exp_pop) void'(ej_model.pop_front());
        if (flit[16]) begin
            if (!was_full || exp_pop) ej_model.push_back(flit);
            else ovf_exp = 1'b1;
        end
        $display("eject in=%h rdy=%0d pop=%0d occ=%0d", flit, rdy, ej_pop, ej_model.size());
        cycle();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        ej_model.delete();
        ovf_exp = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] f;

        // Reset state, with inputs that would expose ungated outputs.
        rst = 1'b0; body_valid = 1'b1; ej_ready = 1'b1;
        cycle();
        cycle();
        chk(32'(noc_data_out), 0, "rst_noc_data");
        chk(32'(req_ready), 1, "rst_req_ready");
        chk(32'(body_ready), 0, "rst_body_ready");
        chk(32'(ej_valid), 0, "rst_ej_valid");
        chk(32'(ej_pop), 0, "rst_ej_pop");
        chk(32'(ej_ovf), 0, "rst_ej_ovf");
        body_valid = 1'b0; ej_ready = 1'b0;
        rst = 1'b1;
        cycle();

        // Directed packet with known flit values.
        fixed_words.push_back(14'h00AA);
        fixed_words.push_back(14'h00BB);
        run_packet(4'h3, 3'd2, 0, 0, 0);
        chk(32'(got[0]), 32'h18C50, "t1_header");
        chk(32'(got[1]), 32'h100AA, "t1_body0");
        chk(32'(got[2]), 32'h140BB, "t1_tail");

        // Three cycles of back-pressure in BODY.
        run_packet(4'h7, 3'd3, 0, 3, 0);

        // Zero length becomes a single tail-carrying body flit.
        run_packet(4'h2, 3'd0, 10, 0, 0);
        chk(got.size(), 2, "len0_flits");
        chk(32'(got[1][14]), 1, "len0_tail");

        // Randomized packets with random stalls.
        for (int p = 0; p < 8; p++) begin
            run_packet(4'($urandom), 3'($urandom), 30, 0, 0);
        end

        // Eject: fill, overflow, drain.
        for (int i = 0; i < 4; i++) ej_step(17'h10100 + 17'(i), 1'b0);
        ej_step(17'h1ABCD, 1'b0);
        ej_step(17'h0, 1'b0);
        pop_seen = 0;
        for (int i = 0; i < 4; i++) ej_step(17'h0, 1'b1);
        chk(pop_seen, 4, "ej_pop_pulses");
        ej_step(17'h0, 1'b1);

        // Eject: push and pop together while full.
        reset_dut();
        for (int i = 0; i < 4; i++) ej_step(17'h12000 + 17'(i), 1'b0);
        ej_step(17'h13333, 1'b1);
        ej_step(17'h0, 1'b0);
        for (int i = 0; i < 4; i++) ej_step(17'h0, 1'b1);
        ej_step(17'h0, 1'b0);

        // Eject: random traffic.
        for (int i = 0; i < 80; i++) begin
            f = 17'($urandom);
            f[16] = ($urandom_range(99) < 60);
            ej_step(f, 1'($urandom_range(1)));
        end
        noc_data_in = '0; ej_ready = 1'b0;

        // Reset in BODY with three body flits still to go.
        reset_dut();
        run_packet(4'h5, 3'd5, 0, 0, 3);
        chk(got.size(), 3, "abort_point");
        #2;
        rst = 1'b0;
        body_valid = 1'b1;
        #1;
        chk(32'(noc_data_out), 0, "abort_noc_data");
        chk(32'(req_ready), 1, "abort_req_ready");
        chk(32'(body_ready), 0, "abort_body_ready");
        req_valid = 1'b0;
        cycle();
        rst = 1'b1;
        body_valid = 1'b0;
        ej_model.delete();
        ovf_exp = 1'b0;
        run_packet(4'hA, 3'd3, 20, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
